// File: rtl/time_set_ctrl_pkg.sv
// time_set_pkg: shared types for the time-set controller
//   state_t   : edit sequencer states
//   editing_t : display select codes driven on the editing output
//   DATA_W    : width of the counter databus and load value
package time_set_pkg;
    localparam int DATA_W = 6;
    typedef enum logic [2:0] {
        RUN, FETCH_MIN, EDIT_MIN, WR_MIN, FETCH_HR, EDIT_HR, WR_HR
    } state_t;
    typedef enum logic [1:0] {
        ED_NONE = 2'd0, ED_MIN = 2'd1, ED_HR = 2'd2
    } editing_t;
endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: button inputs and counter load/data/databus bundle
//   master : the controller (reads buttons and databus, drives enables/loads/data/run/editing)
//   slave  : the surroundings (buttons, minute/hour counters, display)
interface time_set_ctrl_if;
    import time_set_pkg::*;
    logic              btn_mode;
    logic              btn_inc;
    logic [DATA_W-1:0] databus;
    logic              min_en;
    logic              hr_en;
    logic              min_load;
    logic              hr_load;
    logic [DATA_W-1:0] data;
    logic              run;
    logic [1:0]        editing;
    modport master (
        input  btn_mode, btn_inc, databus,
        output min_en, hr_en, min_load, hr_load, data, run, editing
    );
    modport slave (
        output btn_mode, btn_inc, databus,
        input  min_en, hr_en, min_load, hr_load, data, run, editing
    );
endinterface

// File: rtl/time_set_ctrl_btn_pulse.sv
// btn_pulse: 2-flop synchronizer + rising-edge detect giving a registered 1-cycle pulse
//   (3 cycles from input edge to pulse). With AUTO_REPEAT_EN defined and REPEAT=1, a held
//   button also emits a pulse after REPEAT_DLY held cycles and then every REPEAT_PER cycles
//   while hold_en stays high.
//   clk, clear_n (async active-low), btn (async level), [hold_en], pulse
module btn_pulse
`ifdef AUTO_REPEAT_EN
#(
    parameter bit REPEAT     = 1'b0,
    parameter int REPEAT_DLY = 500,
    parameter int REPEAT_PER = 100
)
`endif
(
    input  logic clk,
    input  logic clear_n,
    input  logic btn,
`ifdef AUTO_REPEAT_EN
    input  logic hold_en,
`endif
    output logic pulse
);
    logic [2:0] sh;
    logic       fire;
`ifdef AUTO_REPEAT_EN
    localparam int CW = $clog2((REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1);
    logic [CW-1:0] cnt;
    logic          rep;
    logic          held;
    // cnt equals the number of cycles held so far; after a fire it restarts at 1
    assign held = REPEAT && sh[1] && hold_en;
    assign fire = held && (cnt == CW'(rep ? REPEAT_PER : REPEAT_DLY));
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt <= '0;
            rep <= 1'b0;
        end else if (!held) begin
            cnt <= '0;
            rep <= 1'b0;
        end else if (fire) begin
            cnt <= CW'(1);
            rep <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign fire = 1'b0;
`endif
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sh    <= '0;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[1:0], btn};
            pulse <= (sh[1] & ~sh[2]) | fire;
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: sets minutes then hours from two buttons by fetching each counter over the
//   shared databus, editing a local copy and writing it back with a one-cycle load strobe.
//   Ports: clk, clear_n (async active-low), bus (time_set_ctrl_if.master).
//   Optional feature: define AUTO_REPEAT_EN for auto-repeat of a held increment button.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int MIN_MOD     = 60,
    parameter int HR_MOD      = 24,
    parameter int TIMEOUT_CYC = 1000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DLY  = 500,
    parameter int REPEAT_PER  = 100
`endif
)(
    input  logic             clk,
    input  logic             clear_n,
    time_set_ctrl_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    state_t            state, nxt;
    logic [DATA_W-1:0] edit;
    logic [TW-1:0]     tcnt;
    logic              mode_p, inc_p;
    logic              edit_st, fetch_st, timeout;
    logic [DATA_W:0]   lim;

    btn_pulse
`ifdef AUTO_REPEAT_EN
        #(.REPEAT(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
    u_mode (
        .clk     (clk),
        .clear_n (clear_n),
        .btn     (bus.btn_mode),
`ifdef AUTO_REPEAT_EN
        .hold_en (1'b0),
`endif
        .pulse   (mode_p)
    );

    btn_pulse
`ifdef AUTO_REPEAT_EN
        #(.REPEAT(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER))
`endif
    u_inc (
        .clk     (clk),
        .clear_n (clear_n),
        .btn     (bus.btn_inc),
`ifdef AUTO_REPEAT_EN
        .hold_en (edit_st),
`endif
        .pulse   (inc_p)
    );

    assign edit_st  = (state == EDIT_MIN) || (state == EDIT_HR);
    assign fetch_st = (state == FETCH_MIN) || (state == FETCH_HR);
    // one bit wider than the data so a modulus of 2**DATA_W still compares correctly
    assign lim      = (state == FETCH_HR || state == EDIT_HR) ? (DATA_W+1)'(HR_MOD) : (DATA_W+1)'(MIN_MOD);
    assign timeout  = edit_st && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= RUN;
        else          state <= nxt;
    end

    // mode is tested before timeout so a press on the last idle cycle still commits
    always_comb begin
        nxt = state;
        case (state)
            RUN:       nxt = mode_p ? FETCH_MIN : RUN;
            FETCH_MIN: nxt = EDIT_MIN;
            EDIT_MIN:  nxt = mode_p ? WR_MIN : timeout ? RUN : EDIT_MIN;
            WR_MIN:    nxt = FETCH_HR;
            FETCH_HR:  nxt = EDIT_HR;
            EDIT_HR:   nxt = mode_p ? WR_HR : timeout ? RUN : EDIT_HR;
            WR_HR:     nxt = RUN;
            default:   nxt = RUN;
        endcase
    end

    // out-of-range fetched values are clamped to 0; an increment coinciding with mode is dropped
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            edit <= '0;
            tcnt <= '0;
        end else begin
            if (fetch_st)
                edit <= ({1'b0, bus.databus} >= lim) ? '0 : bus.databus;
            else if (edit_st && inc_p && !mode_p)
                edit <= (({1'b0, edit} + 1'b1) == lim) ? '0 : edit + 1'b1;
            tcnt <= (!edit_st || inc_p || mode_p) ? '0 : tcnt + 1'b1;
        end
    end

    always_comb begin
        bus.min_en   = state == FETCH_MIN;
        bus.hr_en    = state == FETCH_HR;
        bus.min_load = state == WR_MIN;
        bus.hr_load  = state == WR_HR;
        bus.data     = (state == WR_MIN || state == WR_HR) ? edit : '0;
        bus.run      = state == RUN;
        bus.editing  = state == EDIT_MIN ? ED_MIN : state == EDIT_HR ? ED_HR : ED_NONE;
    end
endmodule
